// File: rtl/masku_result_packer.sv
// Mask-unit result packer: gathers bit-positioned compare-result beats into
// full NrLanes*ELEN mask words and hands them to the VRF write path.

package ara_pkg;
    localparam int unsigned ELEN = 64;
    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;
endpackage

module masku_result_packer
    import ara_pkg::*;
#(
    parameter  int unsigned NrLanes = 4,
    localparam int unsigned DW      = NrLanes * ELEN,
    localparam int unsigned PW      = $clog2(DW) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [31:0]   vl_i,
    input  vew_e          vsew_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_bits_i,
    input  logic [DW-1:0] in_bit_en_i,
    input  logic [DW-1:0] old_vd_i,
    output logic [PW-1:0] vrf_pnt_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned EPB_MAX = NrLanes * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [PW-1:0] pnt_q, pnt_d;
    logic [31:0]   remaining_q, remaining_d;
    vew_e          vsew_q, vsew_d;
    logic          last_word_q, last_word_d;
    logic          done_q, done_d;

    logic [PW-1:0] epb;
    logic [PW:0]   pnt_end;
    logic [31:0]   take;
    logic [31:0]   rem_next;
    logic          word_full;
    logic [DW-1:0] base;
    logic [DW-1:0] win;
    logic [DW-1:0] merged;

    assign epb       = PW'(EPB_MAX >> vsew_q);
    assign pnt_end   = {1'b0, pnt_q} + {1'b0, epb};
    assign take      = (remaining_q < 32'(epb)) ? remaining_q : 32'(epb);
    assign rem_next  = remaining_q - take;
    assign word_full = (pnt_end == (PW + 1)'(DW));

    // The first beat of a word starts from the old destination so that
    // disabled and tail bits stay undisturbed.
    assign base = (pnt_q == '0) ? old_vd_i : acc_q;

    generate
        for (genvar gi = 0; gi < int'(DW); gi++) begin : g_bit
            localparam logic [PW:0] IDX = (PW + 1)'(gi);
            assign win[gi]    = ({1'b0, pnt_q} <= IDX) && (IDX < pnt_end);
            assign merged[gi] = (win[gi] && in_bit_en_i[gi]) ? in_bits_i[gi] : base[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pnt_d       = pnt_q;
        remaining_d = remaining_q;
        vsew_d      = vsew_q;
        last_word_d = last_word_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (vl_i != 32'd0) begin
                        state_d     = ACCUM;
                        remaining_d = vl_i;
                        pnt_d       = '0;
                        vsew_d      = vsew_i;
                        last_word_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (in_valid_i) begin
                    acc_d       = merged;
                    remaining_d = rem_next;
                    pnt_d       = pnt_end[PW-1:0];
                    if (word_full || (rem_next == 32'd0)) begin
                        state_d     = FLUSH;
                        last_word_d = (rem_next == 32'd0);
                    end
                end
            end
            FLUSH: begin
                if (out_ready_i) begin
                    pnt_d = '0;
                    if (last_word_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            pnt_q       <= '0;
            remaining_q <= '0;
            vsew_q      <= EW8;
            last_word_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pnt_q       <= pnt_d;
            remaining_q <= remaining_d;
            vsew_q      <= vsew_d;
            last_word_q <= last_word_d;
            done_q      <= done_d;
        end
    end

    // Handshake outputs decode from registered state only.
    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == FLUSH);
    assign out_last_o  = (state_q == FLUSH) && last_word_q;
    assign busy_o      = (state_q != IDLE);
    assign out_data_o  = acc_q;
    assign vrf_pnt_o   = pnt_q;
    assign done_o      = done_q;

endmodule
